vga_rect_fill_engine: RTL



---
 rtl/vga_bus_pkg.sv | 26 ++
 rtl/vga_rect_fill_engine_if.sv | 19 +
 rtl/vga_raster_counter.sv | 64 ++++++
 rtl/vga_rect_fill_engine.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vga_bus_pkg.sv
// rtl/vga_bus_pkg.sv - shared constants and FSM state type for the VGA rectangle fill engine
package vga_bus_pkg;

  localparam int          SCREEN_W_DEF  = 160;
  localparam int          SCREEN_H_DEF  = 120;
  localparam logic [7:0]  BASE_ADDR_DEF = 8'hB0;

  localparam logic [7:0]  REG_X   = 8'd0;
  localparam logic [7:0]  REG_Y   = 8'd1;
  localparam logic [7:0]  REG_COL = 8'd2;
  localparam logic [7:0]  REG_STB = 8'd3;
  localparam logic [7:0]  STB_VAL = 8'h01;

  typedef enum logic [3:0] {
    IDLE,
    CLIP,
    REQ,
    WR_COL,
    WR_X,
    WR_Y,
    WR_STB,
    STEP,
    FIN
  } fill_state_e;

endpackage

// File: rtl/vga_rect_fill_engine_if.sv
// rtl/vga_rect_fill_engine_if.sv - shared VGA peripheral bus seen by the fill engine
interface vga_rect_fill_engine_if;
  logic       BUS_REQ;
  logic       BUS_GNT;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA_OUT;
  logic       BUS_DATA_OE;
  logic       BUS_WE;

  modport master (
    output BUS_REQ, BUS_ADDR, BUS_DATA_OUT, BUS_DATA_OE, BUS_WE,
    input  BUS_GNT
  );

  modport slave (
    input  BUS_REQ, BUS_ADDR, BUS_DATA_OUT, BUS_DATA_OE, BUS_WE,
    output BUS_GNT
  );
endinterface

// File: rtl/vga_raster_counter.sv
// rtl/vga_raster_counter.sv - X/Y cursor walking a clipped rectangle in raster order
module vga_raster_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [7:0] xe,
  input  logic [6:0] y0,
  input  logic [6:0] ye,
  output logic [7:0] x_nxt,
  output logic [6:0] y_nxt,
  output logic       row_start,
  output logic       last
);

  logic [7:0] x_q, x_d, x0_q, x0_d, xe_q, xe_d;
  logic [6:0] y_q, y_d, ye_q, ye_d;

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    x0_d = x0_q;
    xe_d = xe_q;
    ye_d = ye_q;
    if (load) begin
      x_d  = x0;
      y_d  = y0;
      x0_d = x0;
      xe_d = xe;
      ye_d = ye;
    end else if (step) begin
      if (x_q == xe_q) begin
        x_d = x0_q;
        y_d = y_q + 7'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q  <= '0;
      y_q  <= '0;
      x0_q <= '0;
      xe_q <= '0;
      ye_q <= '0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      x0_q <= x0_d;
      xe_q <= xe_d;
      ye_q <= ye_d;
    end
  end

  // next-cycle cursor lets the caller register bus data in step with the FSM
  assign x_nxt     = x_d;
  assign y_nxt     = y_d;
  assign row_start = (x_q == x0_q);
  assign last      = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/vga_rect_fill_engine.sv
// rtl/vga_rect_fill_engine.sv - turns a fill-rectangle command into per-pixel VGA register writes
module vga_rect_fill_engine
  import vga_bus_pkg::*;
#(
  parameter int         SCREEN_W  = SCREEN_W_DEF,
  parameter int         SCREEN_H  = SCREEN_H_DEF,
  parameter logic [7:0] BASE_ADDR = BASE_ADDR_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] X0,
  input  logic [6:0] Y0,
  input  logic [7:0] W,
  input  logic [6:0] H,
  input  logic [7:0] COLOUR,
  output logic       BUSY,
  output logic       DONE,
  vga_rect_fill_engine_if.master bus
);

  fill_state_e state_q, state_d;
  logic [7:0]  x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [6:0]  y0_q, y0_d, h_q, h_d;
  logic        fresh_q, fresh_d, lost_q, lost_d;
  logic        busy_q, busy_d, done_q, done_d, req_q, req_d, oe_q, oe_d, we_q, we_d;
  logic [7:0]  addr_q, addr_d, data_q, data_d;

  logic        cnt_load, cnt_step, row_start, last, empty;
  logic [7:0]  x_nxt, clip_xe;
  logic [6:0]  y_nxt, clip_ye;
  logic [8:0]  x_end, y_end, x_lim, y_lim;
  logic        gnt;

  assign gnt = bus.BUS_GNT;

  always_comb begin
    x_end   = {1'b0, x0_q} + {1'b0, w_q};
    y_end   = {2'b0, y0_q} + {2'b0, h_q};
    x_lim   = (x_end > 9'(SCREEN_W)) ? 9'(SCREEN_W) : x_end;
    y_lim   = (y_end > 9'(SCREEN_H)) ? 9'(SCREEN_H) : y_end;
    clip_xe = 8'(x_lim - 9'd1);
    clip_ye = 7'(y_lim - 9'd1);
    empty   = (w_q == 8'd0) || (h_q == 7'd0) ||
              ({1'b0, x0_q} >= 9'(SCREEN_W)) || ({2'b0, y0_q} >= 9'(SCREEN_H));
  end

  vga_raster_counter u_cursor (
    .clk       (CLK),
    .rst       (RESET),
    .load      (cnt_load),
    .step      (cnt_step),
    .x0        (x0_q),
    .xe        (clip_xe),
    .y0        (y0_q),
    .ye        (clip_ye),
    .x_nxt     (x_nxt),
    .y_nxt     (y_nxt),
    .row_start (row_start),
    .last      (last)
  );

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    col_d    = col_q;
    fresh_d  = fresh_q;
    lost_d   = lost_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        x0_d    = X0;
        y0_d    = Y0;
        w_d     = W;
        h_d     = H;
        col_d   = COLOUR;
        state_d = CLIP;
      end
      CLIP: if (empty) begin
        state_d = FIN;
      end else begin
        cnt_load = 1'b1;
        state_d  = REQ;
      end
      // every grant (first or regained) restarts the pixel from the colour register
      REQ: if (gnt) begin
        fresh_d = 1'b1;
        lost_d  = 1'b0;
        state_d = WR_COL;
      end
      WR_COL: state_d = gnt ? WR_X : REQ;
      WR_X: begin
        if (!gnt)                      state_d = REQ;
        else if (fresh_q || row_start) state_d = WR_Y;
        else                           state_d = WR_STB;
      end
      WR_Y:   state_d = gnt ? WR_STB : REQ;
      WR_STB: begin
        lost_d  = !gnt;
        state_d = STEP;
      end
      STEP: begin
        fresh_d = 1'b0;
        if (last) begin
          state_d = FIN;
        end else begin
          cnt_step = 1'b1;
          state_d  = (gnt && !lost_q) ? WR_X : REQ;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = state_d inside {REQ, WR_COL, WR_X, WR_Y, WR_STB, STEP};
    busy_d = !(state_d inside {IDLE, FIN});
    done_d = (state_d == FIN);
    we_d   = 1'b0;
    addr_d = 8'h00;
    data_d = 8'h00;
    case (state_d)
      WR_COL: begin we_d = 1'b1; addr_d = BASE_ADDR + REG_COL; data_d = col_q;          end
      WR_X:   begin we_d = 1'b1; addr_d = BASE_ADDR + REG_X;   data_d = x_nxt;          end
      WR_Y:   begin we_d = 1'b1; addr_d = BASE_ADDR + REG_Y;   data_d = {1'b0, y_nxt};  end
      WR_STB: begin we_d = 1'b1; addr_d = BASE_ADDR + REG_STB; data_d = STB_VAL;        end
      default: ;
    endcase
    oe_d = we_d;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      fresh_q <= 1'b0;
      lost_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      req_q   <= 1'b0;
      oe_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      fresh_q <= fresh_d;
      lost_q  <= lost_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      req_q   <= req_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign BUSY             = busy_q;
  assign DONE             = done_q;
  assign bus.BUS_REQ      = req_q;
  assign bus.BUS_ADDR     = addr_q;
  assign bus.BUS_DATA_OUT = data_q;
  assign bus.BUS_DATA_OE  = oe_q;
  assign bus.BUS_WE       = we_q;

endmodule
